// File: rtl/fproc_arbiter_pkg.sv
// Shared types and default widths for the fproc arbiter.
// Optional watchdog is enabled by defining FPROC_ARB_TIMEOUT_EN.
package fproc_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    localparam int DEF_N_CORES        = 4;
    localparam int DEF_ID_WIDTH       = 8;
    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

    // Increment modulo n without a divider.
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/fproc_arbiter_if.sv
// Core-side and fproc-side handshake bundle; master is the arbiter, slave is
// the environment (cores plus the shared fproc).
interface fproc_arbiter_if import fproc_arb_pkg::*; #(
    parameter int N_CORES    = DEF_N_CORES,
    parameter int ID_WIDTH   = DEF_ID_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();
    localparam int CW = $clog2(N_CORES);

    logic [N_CORES-1:0]          core_req;
    logic [N_CORES*ID_WIDTH-1:0] core_id;
    logic [N_CORES-1:0]          core_ready;
    logic [DATA_WIDTH-1:0]       core_data;
    logic                        fproc_req_valid;
    logic [ID_WIDTH-1:0]         fproc_req_id;
    logic [CW-1:0]               fproc_req_core;
    logic                        fproc_req_ack;
    logic                        fproc_resp_valid;
    logic [DATA_WIDTH-1:0]       fproc_resp_data;
    logic                        timeout_err;

    modport master (
        input  core_req, core_id, fproc_req_ack, fproc_resp_valid, fproc_resp_data,
        output core_ready, core_data, fproc_req_valid, fproc_req_id, fproc_req_core,
               timeout_err
    );

    modport slave (
        output core_req, core_id, fproc_req_ack, fproc_resp_valid, fproc_resp_data,
        input  core_ready, core_data, fproc_req_valid, fproc_req_id, fproc_req_core,
               timeout_err
    );

endinterface

// File: rtl/fproc_arbiter_rr_select.sv
// Combinational round-robin pick: first pending index at or after rr_ptr_i,
// wrapping modulo N_CORES.
module rr_select import fproc_arb_pkg::*; #(
    parameter int  N_CORES = DEF_N_CORES,
    localparam int CW      = $clog2(N_CORES)
) (
    input  logic [N_CORES-1:0] pending_i,
    input  logic [CW-1:0]      rr_ptr_i,
    output logic [CW-1:0]      grant_idx_o,
    output logic               any_o
);

    int unsigned j;

    // Scan farthest-to-nearest so the candidate closest to the pointer wins.
    always_comb begin
        grant_idx_o = '0;
        any_o       = 1'b0;
        j           = 0;
        for (int k = N_CORES - 1; k >= 0; k--) begin
            j = (int'(rr_ptr_i) + k) % N_CORES;
            if (pending_i[CW'(j)]) begin
                grant_idx_o = CW'(j);
                any_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fproc_arbiter.sv
// Round-robin arbiter sharing one fproc port among N_CORES cores.
// Define FPROC_ARB_TIMEOUT_EN to add the WAIT-state response watchdog.
module fproc_arbiter import fproc_arb_pkg::*; #(
    parameter int N_CORES        = DEF_N_CORES,
    parameter int ID_WIDTH       = DEF_ID_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input logic             clk,
    input logic             reset,
    fproc_arbiter_if.master bus
);

    localparam int CW = $clog2(N_CORES);

    state_e                state_q;
    logic [CW-1:0]         grant_q;
    logic [CW-1:0]         rr_ptr_q;
    logic [ID_WIDTH-1:0]   req_id_q;
    logic                  valid_q;
    logic [N_CORES-1:0]    ready_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  timeout_q;

    logic [N_CORES-1:0]    pending_q, pending_d;
    logic [N_CORES-1:0]    set_req, clr_req;
    logic [ID_WIDTH-1:0]   id_q [N_CORES];

    logic [CW-1:0]         grant_idx;
    logic                  any_pending;
    logic                  expire;
    logic                  deliver;

    rr_select #(.N_CORES(N_CORES)) u_rr_select (
        .pending_i   (pending_q),
        .rr_ptr_i    (rr_ptr_q),
        .grant_idx_o (grant_idx),
        .any_o       (any_pending)
    );

`ifdef FPROC_ARB_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] wdog_q;

    // Counter sits at zero outside WAIT, so it is cleared on every entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                  wdog_q <= '0;
        else if (state_q != ST_WAIT) wdog_q <= '0;
        else                        wdog_q <= wdog_q + 1'b1;
    end

    assign expire = (state_q == ST_WAIT) && !bus.fproc_resp_valid &&
                    (wdog_q == WW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign expire             = 1'b0;
`endif

    assign deliver   = (state_q == ST_WAIT) && (bus.fproc_resp_valid || expire);
    assign clr_req   = deliver ? (N_CORES'(1) << grant_q) : '0;
    // A new request from the core being completed this cycle re-arms its slot.
    assign set_req   = bus.core_req & (~pending_q | clr_req);
    assign pending_d = (pending_q & ~clr_req) | set_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pending_q <= '0;
        else       pending_q <= pending_d;
    end

    // NOTE: the ID registers are only read behind a pending bit, so they carry
    // no reset; leaving storage arrays unreset keeps them plain enable flops.
    for (genvar i = 0; i < N_CORES; i++) begin : g_id
        always_ff @(posedge clk) begin
            if (set_req[i]) id_q[i] <= bus.core_id[i*ID_WIDTH +: ID_WIDTH];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register in this block sees the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            req_id_q  <= '0;
            valid_q   <= 1'b0;
            ready_q   <= '0;
            data_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            ready_q   <= '0;
            timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (any_pending) begin
                        grant_q  <= grant_idx;
                        req_id_q <= id_q[grant_idx];
                        valid_q  <= 1'b1;
                        state_q  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (bus.fproc_req_ack) begin
                        valid_q <= 1'b0;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (deliver) begin
                        ready_q   <= N_CORES'(1) << grant_q;
                        data_q    <= bus.fproc_resp_valid ? bus.fproc_resp_data : '0;
                        timeout_q <= !bus.fproc_resp_valid;
                        rr_ptr_q  <= CW'(wrap_inc(32'(grant_q), N_CORES));
                        state_q   <= ST_IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.core_ready      = ready_q;
    assign bus.core_data       = data_q;
    assign bus.fproc_req_valid = valid_q;
    assign bus.fproc_req_id    = req_id_q;
    assign bus.fproc_req_core  = grant_q;
    assign bus.timeout_err     = timeout_q;

endmodule
